// File: rtl/mnist_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mnist_uart_rx
// Purpose  : 8N1 UART receiver that locks onto A5 5A framed MNIST images,
//            writes payload bytes to an image RAM and checks an XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module mnist_uart_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 115200,
  parameter int PAYLOAD_LEN  = 98,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       img_wr_en,
  output logic [6:0] img_wr_addr,
  output logic [7:0] img_wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam int c_bps_cnt = CLK_FREQ / UART_BPS;
  localparam int c_cnt_w   = $clog2(c_bps_cnt);
  localparam int c_gap_lim = TIMEOUT_BITS * c_bps_cnt;
  localparam int c_gap_w   = $clog2(c_gap_lim);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {FR_HUNT0, FR_HUNT1, FR_PAYLOAD, FR_CHECK} fr_state_t;

  logic               r_rxd_s1, r_rxd_s2, r_rxd_d;
  rx_state_t          r_rx_state, w_rx_nxt;
  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               w_fall, w_mid, w_end, w_byte_valid, w_byte_ferr;

  fr_state_t          r_fr_state, w_fr_nxt;
  logic [6:0]         r_addr;
  logic [7:0]         r_acc;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               w_timeout, w_abort, w_wr, w_done, w_err, w_clr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  end

  assign w_fall = r_rxd_d & ~r_rxd_s2;
  assign w_mid  = (r_clk_cnt == c_cnt_w'(c_bps_cnt / 2));
  assign w_end  = (r_clk_cnt == c_cnt_w'(c_bps_cnt - 1));

  always_comb begin
    w_rx_nxt     = r_rx_state;
    w_byte_valid = 1'b0;
    w_byte_ferr  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_nxt = RX_START;
      RX_START: begin
        if (w_mid && r_rxd_s2) w_rx_nxt = RX_IDLE;
        else if (w_end)        w_rx_nxt = RX_DATA;
      end
      RX_DATA:  if (w_end && r_bit_cnt == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        // Leave at the stop-bit midpoint so a back-to-back start edge is seen.
        if (w_mid) begin
          w_rx_nxt     = RX_IDLE;
          w_byte_valid = r_rxd_s2;
          w_byte_ferr  = ~r_rxd_s2;
        end
      end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_rx_state <= w_rx_nxt;
      if (r_rx_state == RX_IDLE || w_rx_nxt == RX_IDLE || w_end)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;
      if (r_rx_state == RX_DATA) begin
        if (w_mid) r_shift   <= {r_rxd_s2, r_shift[7:1]};
        if (w_end) r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= 3'd0;
      end
    end
  end

  // Timeout registers exactly c_gap_lim clocks after the last accepted byte.
  assign w_timeout = (r_gap_cnt >= c_gap_w'(c_gap_lim - 1));
  assign w_abort   = w_byte_ferr | w_timeout;

  always_comb begin
    w_fr_nxt = r_fr_state;
    w_wr     = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_clr    = 1'b0;
    case (r_fr_state)
      FR_HUNT0: if (w_byte_valid && r_shift == 8'hA5) w_fr_nxt = FR_HUNT1;
      FR_HUNT1: begin
        if (w_byte_valid) begin
          if (r_shift == 8'h5A) begin
            w_fr_nxt = FR_PAYLOAD;
            w_clr    = 1'b1;
          end else if (r_shift != 8'hA5) begin
            w_fr_nxt = FR_HUNT0;
          end
        end else if (w_abort) begin
          w_err    = 1'b1;
          w_fr_nxt = FR_HUNT0;
        end
      end
      FR_PAYLOAD: begin
        if (w_byte_valid) begin
          w_wr = 1'b1;
          if (r_addr == 7'(PAYLOAD_LEN - 1)) w_fr_nxt = FR_CHECK;
        end else if (w_abort) begin
          w_err    = 1'b1;
          w_fr_nxt = FR_HUNT0;
        end
      end
      FR_CHECK: begin
        if (w_byte_valid) begin
          w_done   = (r_shift == r_acc);
          w_err    = (r_shift != r_acc);
          w_fr_nxt = FR_HUNT0;
        end else if (w_abort) begin
          w_err    = 1'b1;
          w_fr_nxt = FR_HUNT0;
        end
      end
      default: w_fr_nxt = FR_HUNT0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fr_state  <= FR_HUNT0;
      r_addr      <= 7'd0;
      r_acc       <= 8'h00;
      r_gap_cnt   <= '0;
      img_wr_en   <= 1'b0;
      img_wr_addr <= 7'd0;
      img_wr_data <= 8'h00;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 8'h00;
      busy        <= 1'b0;
    end else begin
      r_fr_state <= w_fr_nxt;
      img_wr_en  <= w_wr;
      frame_done <= w_done;
      frame_err  <= w_err;
      busy       <= (w_fr_nxt != FR_HUNT0);
      if (w_byte_valid)
        r_gap_cnt <= c_gap_w'(1);
      else if (r_fr_state != FR_HUNT0 && !w_timeout)
        r_gap_cnt <= r_gap_cnt + 1'b1;
      if (w_clr) begin
        r_addr <= 7'd0;
        r_acc  <= 8'h00;
      end else if (w_wr) begin
        r_addr      <= r_addr + 7'd1;
        r_acc       <= r_acc ^ r_shift;
        img_wr_addr <= r_addr;
        img_wr_data <= r_shift;
      end
      if (w_done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/mnist_uart_rx.md
# mnist_uart_rx

Receive-side counterpart to the board's MNIST bit-sequence UART transmitter. The block deserialises UART bytes from `uart_rxd` and locks onto a framed 28×28 binarised MNIST image: 784 pixel bits packed MSB-first into 98 bytes. It writes each payload byte into an external image RAM and validates an XOR checksum. It sits between the board `uart_rxd` pin and the image buffer that feeds the DA/inference path.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 115200: baud rate. `BPS_CNT = CLK_FREQ/UART_BPS`, which is 434 at the defaults.
- `PAYLOAD_LEN`, 98: payload bytes per frame.
- `TIMEOUT_BITS`, 40: idle gap, in bit periods, that aborts a partially received frame.

Ports:
- `sys_clk` in 1: system clock. This is the only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `uart_rxd` in 1: UART serial input. Idle high, 8N1, LSB first. Asynchronous to `sys_clk`.
- `img_wr_en` out 1: one-cycle write strobe to the image RAM.
- `img_wr_addr` out 7: payload byte index, 0 to `PAYLOAD_LEN-1`.
- `img_wr_data` out 8: payload byte.
- `frame_done` out 1: one-cycle pulse when a frame passes its checksum.
- `frame_err` out 1: one-cycle pulse on checksum mismatch, timeout or framing error inside a frame.
- `frame_cnt` out 8: count of good frames. Wraps from 255 to 0.
- `busy` out 1: high whenever the frame FSM is not in HUNT0.

## Operation
- Input conditioning: `uart_rxd` passes through a 2-FF synchroniser. A falling edge on the synchronised signal while the byte receiver is idle starts a byte.
- Byte receiver:
  - A clock counter runs 0 to `BPS_CNT-1` per bit. Each bit is sampled at count `BPS_CNT/2`.
  - If the start bit samples high, it is a false start and the receiver returns to idle.
  - 8 data bits are shifted in LSB first, then the stop bit is sampled.
  - Stop bit = 1 gives a byte-valid pulse. Stop bit = 0 gives a framing-error pulse and the byte is discarded.
  - In either case the receiver returns to idle right after the stop-bit sample, so it can catch a back-to-back start edge.
- Frame FSM:
  - HUNT0: byte 0xA5 → HUNT1. Any other byte → stay. Framing errors are ignored silently.
  - HUNT1: 0x5A → PAYLOAD, with address and XOR accumulator cleared. 0xA5 → stay in HUNT1. Any other byte → HUNT0, with no error.
  - PAYLOAD: each byte is written to `img_wr_addr` and XORed into the accumulator, and the address increments. After write `PAYLOAD_LEN-1` → CHECK.
  - CHECK: byte equal to the accumulator → `frame_done`, `frame_cnt`+1, HUNT0. Any other byte → `frame_err`, HUNT0.
- Abort conditions in HUNT1, PAYLOAD or CHECK:
  - A framing error, or a gap of more than `TIMEOUT_BITS*BPS_CNT` clocks since the last byte-valid, pulses `frame_err` once and returns to HUNT0.
  - The gap counter clears on every byte-valid and is frozen in HUNT0.
  - Payload bytes already written stay in the RAM. The consumer must rely on `frame_done` only.
- A byte-valid and a timeout in the same cycle: the byte wins and the timeout is not flagged.

## Timing
- All outputs are registered. Reset values: `img_wr_en`=0, `img_wr_addr`=0, `img_wr_data`=0x00, `frame_done`=0, `frame_err`=0, `frame_cnt`=0, `busy`=0. Reset also puts the FSM in HUNT0 and the byte receiver in idle.
- Byte-valid is internal and asserts in the cycle of the stop-bit sample. `img_wr_en`, `frame_done` and `frame_err` assert in the following cycle for exactly 1 cycle.
- From the stop-bit midpoint on `uart_rxd`, latency is 3 cycles (2 synchroniser stages plus 1 output register).
- `img_wr_addr` and `img_wr_data` are valid during `img_wr_en` and hold their values until the next write.
- `frame_cnt` updates in the same cycle as `frame_done`.
- `busy` rises on the cycle after 0xA5 is accepted and falls together with the `frame_done` or `frame_err` pulse.
- Reset asserted mid-frame: outputs clear immediately and no `frame_done` or `frame_err` is issued for the aborted frame.

## Test plan
Common setup: `CLK_FREQ`=50 MHz, 115200 baud, so one bit period is 434 clocks (8680 ns).
- Good frame: send A5 5A, then payload 0x00..0x61, then checksum 0x01. Expect 98 writes with addr n and data n, then one `frame_done`, `frame_cnt`=1, no `frame_err`, and `busy` low afterwards.
- Bad checksum: the same frame with checksum 0x00. Expect 98 writes, one `frame_err`, no `frame_done`, and `frame_cnt` unchanged.
- Header resync: send 12 A5 A5 5A followed by a good frame body. Expect the frame accepted with writes starting at addr 0 and `frame_done` pulsed.
- Timeout: send A5 5A and 10 payload bytes, then hold the line idle. Expect `frame_err` exactly 17360 clocks after the 10th byte-valid, then a following good frame is accepted.
- Framing error and glitch:
  - Force stop bit = 0 on payload byte 5. Expect `frame_err`, no write to addr 5, and FSM back in HUNT0.
  - Apply a 100-clock low glitch on an idle line. Expect no byte-valid and no write.
- Reset mid-payload: assert `sys_rst_n`=0 after 40 payload bytes. Expect all outputs at reset values and `frame_cnt`=0. After release, a good frame completes normally.
